// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-input stream multiplexer.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Channel-id width, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter: first requester after ptr wins; grant is gated by adv.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         adv,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  always_comb begin
    int   c;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    // Search ptr+1 .. ptr+N so the last winner has lowest priority.
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!found && req[c]) begin
        found     = 1'b1;
        grant_idx = W'(c);
      end
    end
    if (found && adv) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-input valid/ready stream mux with a registered output stage.
// Selection is either external (sel) or round-robin among valid inputs.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int MODE   = 0,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     sel_err,
  input  logic                     sel_err_clr
);

  localparam int SEL_SPAN = 1 << SEL_W;

  // Handshake: a word moves on an input when in_valid[i] && in_ready[i], and on
  // the output when out_valid && out_ready; in_valid must not wait on in_ready.
  logic                load_en;
  logic [NUM_CH-1:0]   grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                in_xfer;
  logic [SEL_SPAN-1:0] sel_ok_vec;

  assign load_en  = !out_valid || out_ready;
  assign in_ready = grant & {NUM_CH{rst_n}};
  assign in_xfer  = |(in_valid & in_ready);

  always_comb begin
    sel_ok_vec = '0;
    for (int i = 0; i < SEL_SPAN; i++) sel_ok_vec[i] = (i < NUM_CH);
  end

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] ptr;

      rr_arbiter #(.N(NUM_CH), .W(SEL_W)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .adv       (load_en),
        .grant     (grant),
        .grant_idx (grant_idx)
      );

      // Reset to the last channel so channel 0 is searched first.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ptr <= SEL_W'(NUM_CH - 1);
        else if (in_xfer) ptr <= grant_idx;
      end
    end else begin : g_sel
      always_comb begin
        grant = '0;
        if (sel_ok_vec[sel] && load_en) grant[sel] = 1'b1;
      end
      assign grant_idx = sel;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_ch    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear has priority over a same-cycle out-of-range select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    sel_err <= 1'b0;
    else if (sel_err_clr)                          sel_err <= 1'b0;
    else if (MODE == MODE_SEL && !sel_ok_vec[sel]) sel_err <= 1'b1;
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: select mode (4 and 3 channels) and round-robin mode.
module tb_stream_mux_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Select-mode instance, 4 channels
  logic [3:0]  s_valid, s_ready;
  logic [31:0] s_data;
  logic [1:0]  s_sel, s_och;
  logic        s_ov, s_oready, s_err, s_clr;
  logic [7:0]  s_od;

  // Round-robin instance, 4 channels
  logic [3:0]  r_valid, r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_sel, r_och;
  logic        r_ov, r_oready, r_err, r_clr;
  logic [7:0]  r_od;

  // Select-mode instance, 3 channels
  logic [2:0]  t_valid, t_ready;
  logic [23:0] t_data;
  logic [1:0]  t_sel, t_och;
  logic        t_ov, t_oready, t_err, t_clr;
  logic [7:0]  t_od;

  stream_mux_n #(.NUM_CH(4), .DATA_W(8), .MODE(0)) u_sel (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data),
    .sel(s_sel), .out_valid(s_ov), .out_ready(s_oready), .out_data(s_od), .out_ch(s_och),
    .sel_err(s_err), .sel_err_clr(s_clr));

  stream_mux_n #(.NUM_CH(4), .DATA_W(8), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(r_valid), .in_ready(r_ready), .in_data(r_data),
    .sel(r_sel), .out_valid(r_ov), .out_ready(r_oready), .out_data(r_od), .out_ch(r_och),
    .sel_err(r_err), .sel_err_clr(r_clr));

  stream_mux_n #(.NUM_CH(3), .DATA_W(8), .MODE(0)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_valid), .in_ready(t_ready), .in_data(t_data),
    .sel(t_sel), .out_valid(t_ov), .out_ready(t_oready), .out_data(t_od), .out_ch(t_och),
    .sel_err(t_err), .sel_err_clr(t_clr));

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_ch;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [1:0] e;

    vecs[0] = '{2'd2, 4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[1] = '{2'd0, 4'b0001, 32'h0000_003C, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0};
    vecs[2] = '{2'd1, 4'b0000, 32'h0000_0000, 1'b1, 4'b0010, 1'b0, 8'h3C, 2'd0};
    vecs[3] = '{2'd3, 4'b1000, 32'h7E00_0000, 1'b0, 4'b1000, 1'b1, 8'h7E, 2'd3};
    vecs[4] = '{2'd3, 4'b1000, 32'h9900_0000, 1'b0, 4'b0000, 1'b1, 8'h7E, 2'd3};
    vecs[5] = '{2'd1, 4'b0010, 32'h0000_4400, 1'b1, 4'b0010, 1'b1, 8'h44, 2'd1};
    vecs[6] = '{2'd2, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd1};
    vecs[7] = '{2'd2, 4'b0000, 32'h0000_0000, 1'b1, 4'b0100, 1'b0, 8'h44, 2'd1};

    // Reset, with requests pending that must not be acknowledged
    rst_n = 1'b0;
    s_valid = 4'b0100; s_data = 32'h00A5_0000; s_sel = 2'd2; s_oready = 1'b1; s_clr = 1'b0;
    r_valid = 4'hF; r_data = '0; r_sel = '0; r_oready = 1'b1; r_clr = 1'b0;
    t_valid = '0; t_data = '0; t_sel = '0; t_oready = 1'b1; t_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready_sel", 64'(s_ready), 64'h0);
    check("rst_in_ready_rr", 64'(r_ready), 64'h0);
    check("rst_out_valid", 64'(s_ov), 64'h0);
    check("rst_out_data", 64'(s_od), 64'h0);
    check("rst_out_ch", 64'(s_och), 64'h0);
    check("rst_sel_err", 64'(s_err), 64'h0);
    s_valid = '0; s_sel = '0; r_valid = '0;
    rst_n = 1'b1;

    // Select mode: table-driven
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_sel = vecs[i].sel; s_valid = vecs[i].valid; s_data = vecs[i].data; s_oready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), 64'(s_ready), 64'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d_out_valid", i), 64'(s_ov), 64'(vecs[i].exp_ov));
      check($sformatf("v%0d_out_data", i), 64'(s_od), 64'(vecs[i].exp_od));
      check($sformatf("v%0d_out_ch", i), 64'(s_och), 64'(vecs[i].exp_ch));
    end

    // Select mode backpressure: 0x11 held while sel moves to a valid ch1
    @(negedge clk);
    s_sel = 2'd0; s_valid = 4'b0001; s_data = 32'h0000_0011; s_oready = 1'b0;
    @(posedge clk); #1;
    check("bp_load_data", 64'(s_od), 64'h11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_sel = 2'd1; s_valid = 4'b0010; s_data = 32'h0000_2200; s_oready = 1'b0;
      #1;
      check($sformatf("bp_stall%0d_in_ready", i), 64'(s_ready), 64'h0);
      @(posedge clk); #1;
      check($sformatf("bp_stall%0d_data", i), 64'(s_od), 64'h11);
      check($sformatf("bp_stall%0d_valid", i), 64'(s_ov), 64'h1);
    end
    @(negedge clk);
    s_oready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(s_ready), 64'b0010);
    @(posedge clk); #1;
    check("bp_next_data", 64'(s_od), 64'h22);
    check("bp_next_ch", 64'(s_och), 64'h1);
    @(negedge clk);
    s_valid = '0;
    @(posedge clk); #1;
    check("bp_drain_valid", 64'(s_ov), 64'h0);

    // Three-channel select mode: out-of-range select and sticky error
    @(negedge clk);
    t_sel = 2'd3; t_valid = 3'b111; t_data = 24'h0B0A0C; t_oready = 1'b1;
    #1;
    check("s3_bad_in_ready", 64'(t_ready), 64'h0);
    @(posedge clk); #1;
    check("s3_err_set", 64'(t_err), 64'h1);
    check("s3_bad_no_out", 64'(t_ov), 64'h0);
    @(negedge clk);
    t_sel = 2'd0;
    #1;
    check("s3_ok_in_ready", 64'(t_ready), 64'b001);
    @(posedge clk); #1;
    check("s3_err_sticky", 64'(t_err), 64'h1);
    check("s3_ok_data", 64'(t_od), 64'h0C);
    @(negedge clk);
    t_clr = 1'b1;
    @(posedge clk); #1;
    check("s3_err_clr", 64'(t_err), 64'h0);
    @(negedge clk);
    t_sel = 2'd3;
    @(posedge clk); #1;
    check("s3_clr_wins", 64'(t_err), 64'h0);
    @(negedge clk);
    t_clr = 1'b0; t_sel = 2'd0; t_valid = '0;
    @(posedge clk); #1;
    check("s3_err_stays_clear", 64'(t_err), 64'h0);

    // Round-robin: all channels valid, one word per clock
    @(negedge clk);
    r_valid = 4'hF; r_data = 32'h1312_1110; r_oready = 1'b1;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      check("rr_all_valid", 64'(r_ov), 64'h1);
      check("rr_all_ch", 64'(r_och), 64'(e));
      check("rr_all_data", 64'(r_od), 64'h10 + 64'(e));
    end

    // Round-robin: only ch1 and ch3 requesting
    exp_q = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
    @(negedge clk);
    r_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("rr_idle_not_granted", 64'(r_ready & 4'b0101), 64'h0);
      e = exp_q.pop_front();
      @(posedge clk); #1;
      check("rr_sparse_ch", 64'(r_och), 64'(e));
      check("rr_sparse_valid", 64'(r_ov), 64'h1);
    end
    @(negedge clk);
    r_oready = 1'b0;
    #1;
    check("rr_stall_in_ready", 64'(r_ready), 64'h0);
    @(posedge clk); #1;
    check("rr_stall_hold", 64'(r_och), 64'h3);

    // Reset mid-stream while a word is held
    @(negedge clk);
    r_valid = 4'b0001; r_data = 32'h0000_005A; r_oready = 1'b1;
    @(posedge clk); #1;
    check("mid_load", 64'(r_od), 64'h5A);
    @(negedge clk);
    r_valid = '0; r_oready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(r_ov), 64'h0);
    check("mid_rst_data", 64'(r_od), 64'h0);
    @(negedge clk);
    r_valid = 4'hF; r_data = 32'h1312_1110; r_oready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 64'(r_ov), 64'h1);
    check("post_rst_ch", 64'(r_och), 64'h0);

    check("sel4_never_err", 64'(s_err), 64'h0);
    check("rr_never_err", 64'(r_err), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised successor of the team's 2:1 combinational mux: selects one of NUM_CH input streams, each DATA_W bits wide, onto a single registered output stream.
- Every input and the output use a valid/ready handshake.
- Two selection modes: external select, or internal round-robin arbitration.
- Sits between multiple producers (sample channels, UART/ADC front-ends) and a single consumer. Registered output breaks the combinational data path.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel in bits (1..64).
- MODE, 0, 0 = external select via sel; 1 = round-robin among valid inputs.
- SEL_W, $clog2(NUM_CH), select/channel-id width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- sel  in  SEL_W  channel select; used only when MODE=0.
- out_valid  out  1  output data valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  selected data (registered).
- out_ch  out  SEL_W  channel index of out_data (registered).
- sel_err  out  1  sticky: sel >= NUM_CH was seen while MODE=0.
- sel_err_clr  in  1  synchronous clear of sel_err.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, out_data=0, out_ch=0, sel_err=0.
  - Round-robin pointer = NUM_CH-1, so channel 0 has first priority.
  - in_ready=0 while rst_n is low.
- Load condition: load_en = !out_valid || out_ready, i.e. the output register is empty or is draining this cycle.
- Grant, MODE=0:
  - grant = one-hot(sel) if sel < NUM_CH, else none.
  - Select is sampled combinationally each cycle; a change takes effect on the next transfer only and never alters out_data already held.
- Grant, MODE=1:
  - Grant the first channel with in_valid=1, searching from ptr+1 upward, modulo NUM_CH.
  - No valid input means no grant.
  - On a transfer from channel k, ptr <= k.
- Handshake:
  - in_ready[i] = grant[i] && load_en && rst_n.
  - Input transfer: in_valid[i] && in_ready[i]. On it, out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - Output transfer: out_valid && out_ready. With no input transfer in the same cycle, out_valid <= 0.
  - Simultaneous output and input transfer: register reloads; out_valid stays 1. Full throughput is 1 word/clock.
  - While out_valid=1 && out_ready=0: out_data and out_ch hold stable, and all in_ready=0.
  - in_valid must not depend on in_ready.
- Latency: 1 clock from input transfer to out_valid.
- sel_err:
  - Set on any clock where MODE=0 and sel >= NUM_CH.
  - sel_err_clr wins over set in the same cycle.
  - Constant 0 when MODE=1.
  - With NUM_CH a power of 2, sel_err can never set.
- Reset mid-operation: a held word is discarded (out_valid falls immediately on rst_n low); ptr returns to NUM_CH-1.

Decomposition:
- Package stream_mux_pkg:
  - MODE_SEL=0, MODE_RR=1 constants.
  - Function clog2_min1: returns at least 1 bit for NUM_CH=1 robustness.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr, adv.
  - Outputs: grant[N] (one-hot), grant_idx.
  - Instantiated only under MODE=1 via generate.

Test Plan:
- MODE=0, NUM_CH=4, DATA_W=8: sel=2, in_data ch2=0xA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. Next clock: out_valid=1, out_data=0xA5, out_ch=2.
- MODE=0 backpressure: word 0x11 held, out_ready=0 for 3 clocks while sel changes to 1 with ch1=0x22 valid -> out_data stays 0x11 and in_ready=0 for all 3 clocks. Raise out_ready -> 0x11 accepted; 0x22 appears the next clock.
- MODE=1: all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive clocks; out_valid stays 1 with no bubbles.
- MODE=1: only ch3 and ch1 valid, ptr after ch3 -> grant order 1,3,1,3; idle channels are never granted.
- MODE=0, NUM_CH=3: sel=3 for 1 clock -> no in_ready, sel_err=1 and stays 1. Pulse sel_err_clr -> sel_err=0 on the next clock.
- Reset mid-stream: out_valid=1 holding 0x5A, drop rst_n asynchronously -> out_valid=0 and out_data=0 before the next clk edge. After release in MODE=1 with all channels valid, the first out_ch=0.
